// File: rtl/sop_sequencer.sv
// sop_sequencer: sequential sum-of-products engine.
// Streams 2*N_PAIRS unsigned operands in over a valid/ready port, multiplies
// them pairwise through a single shared multiplier, accumulates the products
// and presents the sum over a valid/ready output port.

module sop_sequencer #(
    parameter  int W       = 4,
    parameter  int N_PAIRS = 4,
    localparam int RW      = 2 * W + $clog2(N_PAIRS)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          abort_i,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    input  logic [W-1:0]  in_data_i,
    output logic          out_valid_o,
    input  logic          out_ready_i,
    output logic [RW-1:0] out_result_o,
    output logic          busy_o
);

    localparam int CW = $clog2(N_PAIRS);
    localparam logic [CW-1:0] LAST_PAIR = CW'(N_PAIRS - 1);

    typedef enum logic [1:0] {
        LOAD_A = 2'd0,
        LOAD_B = 2'd1,
        FLUSH  = 2'd2,
        DONE   = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic [W-1:0]    aReg_q, aReg_d;
    logic [2*W-1:0]  prodReg_q, prodReg_d;
    logic            prodVld_q, prodVld_d;
    logic [CW-1:0]   pairCnt_q, pairCnt_d;
    logic [RW-1:0]   acc_q, acc_d;

    logic [2*W-1:0]  product;
    logic            inHandshake;
    logic            loadState;

    // The single shared multiplier: the held first operand times the incoming second one.
    assign product = (2 * W)'(aReg_q) * (2 * W)'(in_data_i);

    assign loadState    = (state_q == LOAD_A) || (state_q == LOAD_B);
    assign in_ready_o   = rst_ni & ~abort_i & loadState;
    assign inHandshake  = in_valid_i & in_ready_o;
    assign out_valid_o  = (state_q == DONE);
    assign out_result_o = acc_q;
    assign busy_o       = !((state_q == LOAD_A) && (pairCnt_q == '0));

    // Next-state decode: operand capture, product registration, accumulation, abort override.
    always_comb begin
        state_d   = state_q;
        aReg_d    = aReg_q;
        prodReg_d = prodReg_q;
        prodVld_d = 1'b0;
        pairCnt_d = pairCnt_q;
        acc_d     = acc_q;

        if (prodVld_q) begin
            acc_d = acc_q + RW'(prodReg_q);
        end

        case (state_q)
            LOAD_A: begin
                if (inHandshake) begin
                    aReg_d  = in_data_i;
                    state_d = LOAD_B;
                end
            end
            LOAD_B: begin
                if (inHandshake) begin
                    prodReg_d = product;
                    prodVld_d = 1'b1;
                    if (pairCnt_q == LAST_PAIR) begin
                        state_d = FLUSH;
                    end else begin
                        pairCnt_d = pairCnt_q + CW'(1);
                        state_d   = LOAD_A;
                    end
                end
            end
            FLUSH: begin
                state_d = DONE;
            end
            DONE: begin
                if (out_ready_i) begin
                    acc_d     = '0;
                    pairCnt_d = '0;
                    state_d   = LOAD_A;
                end
            end
            default: begin
                state_d = LOAD_A;
            end
        endcase

        if (abort_i) begin
            state_d   = LOAD_A;
            acc_d     = '0;
            pairCnt_d = '0;
            prodVld_d = 1'b0;
        end
    end

    // State and datapath registers, all cleared by the asynchronous reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= LOAD_A;
            aReg_q    <= '0;
            prodReg_q <= '0;
            prodVld_q <= 1'b0;
            pairCnt_q <= '0;
            acc_q     <= '0;
        end else begin
            state_q   <= state_d;
            aReg_q    <= aReg_d;
            prodReg_q <= prodReg_d;
            prodVld_q <= prodVld_d;
            pairCnt_q <= pairCnt_d;
            acc_q     <= acc_d;
        end
    end

endmodule

// File: tb/tb_sop_sequencer.sv
// tb_sop_sequencer: randomized scoreboard bench for sop_sequencer.
// Stimulus pushes the expected sum of each complete operand set into a queue;
// an independent monitor pops and compares on every output handshake.

module tb_sop_sequencer;

    localparam int W  = 4;
    localparam int NP = 4;
    localparam int RW = 2 * W + $clog2(NP);
    localparam int NOPS = 2 * NP;

    logic          clk;
    logic          rst_n;
    logic          abort;
    logic          inValid;
    logic          inReady;
    logic [W-1:0]  inData;
    logic          outValid;
    logic          outReady;
    logic [RW-1:0] outResult;
    logic          busy;

    int compared;
    int mismatched;
    int expQ[$];
    int ops[NOPS];
    int cyc;
    int acceptCyc;
    int firstAcceptCyc;

    sop_sequencer #(.W(W), .N_PAIRS(NP)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .abort_i      (abort),
        .in_valid_i   (inValid),
        .in_ready_o   (inReady),
        .in_data_i    (inData),
        .out_valid_o  (outValid),
        .out_ready_i  (outReady),
        .out_result_o (outResult),
        .busy_o       (busy)
    );

    // Free-running clock with a 10-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycle counter used to measure result latency.
    always @(posedge clk) cyc++;

    // Hard stop in case some wait is never satisfied.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        compared++;
        if (actual != expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Reference model: sum of pairwise products of the operands in arrival order.
    function automatic int refSum();
        int s = 0;
        for (int i = 0; i < NP; i++) s += ops[2 * i] * ops[2 * i + 1];
        return s;
    endfunction

    // Monitor: every accepted result is compared with the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && outValid && outReady) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpectedResult", int'(outResult), -1);
            end else begin
                checkOutput("result", int'(outResult), expQ.pop_front());
            end
        end
    end

    // Offer one operand and hold it until the block takes it (bounded wait).
    task automatic sendOperand(input int d);
        int guard = 0;
        inValid = 1'b1;
        inData  = W'(d);
        @(negedge clk);
        while (!inReady && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!inReady) checkOutput("acceptTimeout", 0, 1);
        acceptCyc = cyc;
        @(posedge clk);
        #1;
        inValid = 1'b0;
    endtask

    // Send the whole ops[] set with up to maxGap idle cycles between operands.
    task automatic applyStimulus(input int maxGap);
        for (int i = 0; i < NOPS; i++) begin
            sendOperand(ops[i]);
            if (i == 0) firstAcceptCyc = acceptCyc;
            if (i != NOPS - 1) begin
                int g = $urandom_range(0, maxGap);
                for (int k = 0; k < g; k++) begin
                    @(negedge clk);
                    checkOutput("gapInReady", int'(inReady), 1);
                    @(posedge clk);
                    #1;
                end
            end
        end
        expQ.push_back(refSum());
    endtask

    task automatic waitOutValid();
        int guard = 0;
        @(negedge clk);
        while (!outValid && guard < 30) begin
            @(negedge clk);
            guard++;
        end
        if (!outValid) checkOutput("outValidTimeout", 0, 1);
    endtask

    // Wait for the result, optionally stall the consumer, then take it.
    task automatic collectResult(input int maxHold);
        int n;
        waitOutValid();
        if (!outReady) begin
            n = $urandom_range(0, maxHold);
            for (int k = 0; k < n; k++) begin
                @(posedge clk);
                #1;
                @(negedge clk);
                checkOutput("stallValid", int'(outValid), 1);
                checkOutput("stallResult", int'(outResult), refSum());
            end
            @(posedge clk);
            #1;
            outReady = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic fillConst(input int v);
        for (int i = 0; i < NOPS; i++) ops[i] = v;
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        cyc        = 0;
        rst_n      = 1'b0;
        abort      = 1'b0;
        inValid    = 1'b0;
        inData     = '0;
        outReady   = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        checkOutput("rstInReady", int'(inReady), 0);
        checkOutput("rstOutValid", int'(outValid), 0);
        checkOutput("rstOutResult", int'(outResult), 0);
        checkOutput("rstBusy", int'(busy), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("postRstInReady", int'(inReady), 1);
        @(posedge clk);
        #1;

        // Operands 1..8 back-to-back: latency and result 100
        for (int i = 0; i < NOPS; i++) ops[i] = i + 1;
        applyStimulus(0);
        @(negedge clk);
        checkOutput("flushInReady", int'(inReady), 0);
        checkOutput("flushBusy", int'(busy), 1);
        checkOutput("flushOutValid", int'(outValid), 0);
        waitOutValid();
        checkOutput("latencyCycle", cyc - firstAcceptCyc + 1, 10);
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("reloadInReady", int'(inReady), 1);
        checkOutput("reloadBusy", int'(busy), 0);
        @(posedge clk);
        #1;

        // Extreme constant sets with one idle cycle between them
        fillConst(15); applyStimulus(0); collectResult(0); idle(1);
        fillConst(0);  applyStimulus(0); collectResult(0); idle(1);
        fillConst(1);  applyStimulus(0); collectResult(0); idle(1);

        // Alternate-cycle gaps must keep pair alignment
        for (int i = 0; i < NOPS; i++) ops[i] = i + 1;
        for (int i = 0; i < NOPS; i++) begin
            sendOperand(ops[i]);
            if (i != NOPS - 1) begin
                @(negedge clk);
                checkOutput("altGapInReady", int'(inReady), 1);
                @(posedge clk);
                #1;
            end
        end
        expQ.push_back(100);
        collectResult(0);

        // Consumer stall in DONE: result held, operands refused
        outReady = 1'b0;
        for (int i = 0; i < NOPS; i++) ops[i] = i + 1;
        applyStimulus(0);
        waitOutValid();
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            inValid = (k % 2 == 0);
            inData  = W'(7);
            @(negedge clk);
            checkOutput("holdValid", int'(outValid), 1);
            checkOutput("holdResult", int'(outResult), 100);
            checkOutput("holdInReady", int'(inReady), 0);
        end
        @(posedge clk);
        #1;
        inValid  = 1'b0;
        outReady = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("afterHoldInReady", int'(inReady), 1);
        @(posedge clk);
        #1;

        // Abort after three operands, then a clean 2,3 set
        for (int i = 0; i < 3; i++) sendOperand($urandom_range(1, 15));
        abort   = 1'b1;
        inValid = 1'b1;
        inData  = W'(5);
        @(negedge clk);
        checkOutput("abortInReady", int'(inReady), 0);
        @(posedge clk);
        #1;
        abort   = 1'b0;
        inValid = 1'b0;
        @(negedge clk);
        checkOutput("abortBusy", int'(busy), 0);
        @(posedge clk);
        #1;
        for (int i = 0; i < NOPS; i++) ops[i] = (i % 2 == 0) ? 2 : 3;
        applyStimulus(0);
        collectResult(0);

        // Abort in DONE drops the pending result
        outReady = 1'b0;
        fillConst(9);
        for (int i = 0; i < NOPS; i++) sendOperand(ops[i]);
        waitOutValid();
        @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        @(negedge clk);
        checkOutput("abortDoneValid", int'(outValid), 0);
        checkOutput("abortDoneBusy", int'(busy), 0);
        outReady = 1'b1;
        @(posedge clk);
        #1;
        fillConst(1); applyStimulus(0); collectResult(0);

        // Asynchronous reset in the middle of a pair
        for (int i = 0; i < 3; i++) sendOperand($urandom_range(1, 15));
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midRstOutValid", int'(outValid), 0);
        checkOutput("midRstBusy", int'(busy), 0);
        checkOutput("midRstInReady", int'(inReady), 0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("midRstReleaseInReady", int'(inReady), 1);
        @(posedge clk);
        #1;
        fillConst(1); applyStimulus(0); collectResult(0);

        // Randomized sets with random gaps and random consumer stalls
        for (int r = 0; r < 25; r++) begin
            for (int i = 0; i < NOPS; i++) ops[i] = $urandom_range(0, 15);
            outReady = 1'($urandom_range(0, 1));
            applyStimulus(2);
            collectResult(3);
            idle($urandom_range(0, 2));
        end

        // Every expected result must have been delivered
        idle(5);
        checkOutput("pendingResults", expQ.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
